// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports with write-before-read
// bypass, one write port, optional hardwired-zero r0 and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ReadAddr1,
  input  logic [AW-1:0]    ReadAddr2,
  input  logic             ReadEnable1,
  input  logic             ReadEnable2,
  output logic [WIDTH-1:0] Bitline1,
  output logic [WIDTH-1:0] Bitline2,
  input  logic             WriteReg,
  input  logic [AW-1:0]    WriteAddr,
  input  logic [WIDTH-1:0] DstData,
  input  logic             ClearReq,
  output logic             ClearBusy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [0:0]       state;
  logic [AW-1:0]    idx;
  logic             write_ok;

  assign ClearBusy = (state == CLEAR);

  // Writes to r0 are dropped when it is hardwired, and nothing is written during a sweep.
  assign write_ok = WriteReg && !ClearBusy && !((ZERO_REG != 0) && (WriteAddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset on purpose: every register must read 0 after rst.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every update sees pre-edge values.
      case (state)
        IDLE: begin
          if (ClearReq) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          idx      <= idx + 1'b1;
          if (idx == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // write_ok is never true in CLEAR, so this cannot collide with the sweep write.
      if (write_ok) mem[WriteAddr] <= DstData;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    Bitline1 = '0;
    if (ReadEnable1) begin
      if ((ZERO_REG != 0) && (ReadAddr1 == '0)) Bitline1 = '0;
      else if (write_ok && (WriteAddr == ReadAddr1)) Bitline1 = DstData;
      else Bitline1 = mem[ReadAddr1];
    end
  end

  always_comb begin
    Bitline2 = '0;
    if (ReadEnable2) begin
      if ((ZERO_REG != 0) && (ReadAddr2 == '0)) Bitline2 = '0;
      else if (write_ok && (WriteAddr == ReadAddr2)) Bitline2 = DstData;
      else Bitline2 = mem[ReadAddr2];
    end
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file with `DEPTH` registers of `WIDTH` bits. It has two read ports, one write port, internal write-before-read bypass and an optional hardwired-zero register 0. A built-in clear sequencer sweeps every register to zero, one register per cycle, on request. The block sits in the decode stage and supplies both source operands. It also accepts the writeback result in the same cycle.

## Interface
- `WIDTH`, 16: data width in bits.
- `DEPTH`, 16: number of registers; power of two, minimum 2.
- `ZERO_REG`, 1: 1 means register 0 reads as 0 and ignores writes; 0 means register 0 is an ordinary register.
- `AW` (localparam): `$clog2(DEPTH)`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ReadAddr1`, `ReadAddr2`  in  AW: read port addresses.
- `ReadEnable1`, `ReadEnable2`  in  1: read port enables.
- `Bitline1`, `Bitline2`  out  WIDTH: read data; combinational.
- `WriteReg`  in  1: write enable.
- `WriteAddr`  in  AW: write address.
- `DstData`  in  WIDTH: write data.
- `ClearReq`  in  1: starts a full-array clear; level sampled at the clock edge.
- `ClearBusy`  out  1: high while the clear sweep is in progress; registered.

## Operation
- Storage: `DEPTH` x `WIDTH` flops, all loaded by the rising edge of `clk`.
- Write acceptance: a write is accepted when `WriteReg`=1, `ClearBusy`=0, and not (`ZERO_REG`=1 and `WriteAddr`=0).
  - An accepted write updates `reg[WriteAddr]` at the edge.
  - A write that is not accepted is silently dropped.
- Read port n:
  - `ReadEnableN`=0 gives `BitlineN` = 0. Outputs are driven, never high-Z.
  - `ZERO_REG`=1 and `ReadAddrN`=0 gives 0.
  - Bypass: if the write would be accepted this cycle and `WriteAddr`=`ReadAddrN`, then `BitlineN` = `DstData`.
  - Otherwise `BitlineN` = `reg[ReadAddrN]`.
- Both ports are independent. Both may read the same address, including the bypassed one.
- Clear FSM has two states, IDLE and CLEAR, plus an index counter `idx` (AW bits).
  - IDLE: `ClearReq`=1 at an edge moves to CLEAR with `idx`=0.
  - CLEAR: each edge writes 0 to `reg[idx]` and increments `idx`.
  - CLEAR: the edge at which `idx`=`DEPTH`-1 clears the last register and returns to IDLE.
  - `ClearReq` is ignored while in CLEAR; the request is not queued.
  - `ClearBusy` = (state == CLEAR).
- Reads during CLEAR return current contents: registers below `idx` read 0, the rest read their old values. Bypass is disabled during CLEAR because no write is accepted.

## Timing
- Reset (rst=1 at an edge):
  - all registers = 0.
  - state = IDLE, `idx` = 0, `ClearBusy` = 0.
  - Reset overrides an in-progress clear and any write in the same cycle.
- Outputs after reset: `Bitline1`/`Bitline2` = 0 for every address.
- Read latency: 0 cycles, combinational from address/enable/bypass inputs.
- Write latency:
  - the value is visible the same cycle via bypass;
  - it is visible from storage from the next cycle.
- Clear latency:
  - `ClearBusy` rises the cycle after `ClearReq` is sampled.
  - `ClearBusy` stays high exactly `DEPTH` cycles.
  - The first write accepted after a clear is in the cycle `ClearBusy` is low again.
- Write in the same cycle `ClearReq` is sampled in IDLE: the write is accepted (`ClearBusy` still 0), then register `WriteAddr` is cleared by the sweep.
- Counter width: `idx` wraps from `DEPTH`-1 to 0 naturally. No extra bit is needed because the FSM exits on `idx`=`DEPTH`-1.

## Test plan
1. Reset then read: rst=1 for one edge, then read all 16 addresses on both ports with enables=1 -> every `Bitline` = 0x0000 and `ClearBusy`=0.
2. Write/bypass: write 0xBEEF to r5 with ReadAddr1=5 in the same cycle -> `Bitline1`=0xBEEF that cycle; next cycle, with WriteReg=0, `Bitline1`=0xBEEF from storage. With ReadEnable2=0 and ReadAddr2=5 -> `Bitline2`=0x0000.
3. Zero register:
   - `ZERO_REG`=1: write 0x1234 to r0 with ReadAddr1=0 -> `Bitline1`=0 that cycle and after.
   - `ZERO_REG`=0: the same sequence returns 0x1234.
4. Clear sweep:
   - Setup: fill r0..r15 with 0x1000+i.
   - Stimulus: pulse `ClearReq`, then issue a write of 0xAAAA to r3 during busy.
   - Required: `ClearBusy` high for exactly 16 cycles; 2 cycles into busy, r0 and r1 read 0 while r2 reads 0x1002; the r3 write is dropped; all registers read 0 afterwards.
5. Reset mid-clear: assert rst=1 in the 7th busy cycle -> next cycle `ClearBusy`=0 and all registers = 0. A following write of 0x5555 to r9 is accepted immediately.
6. Parameter sweep: WIDTH=32, DEPTH=8, and DEPTH=2 with `ZERO_REG`=0 -> `ClearBusy` lasts 8 and 2 cycles respectively; bypass works at full 32-bit width (0xDEADBEEF).
